arbiter: RTL and testbench
==========================

Name: arbiter

Overview:
- Four-requester round-robin arbiter with registered, one-hot grant outputs.
- Used as the access controller in front of a shared resource: each requester holds its req line high while it needs the resource, and owns the resource while its gnt line is high.
- Fairness: a grant is held (locked) while the owner keeps requesting. On release, priority rotates to the requester after the last owner.

Parameters:
- None. Requester count is fixed at 4.

Ports:
- clk   input  1  rising-edge clock
- rst   input  1  asynchronous reset, active-low (0 = reset)
- req3  input  1  request from requester 3
- req2  input  1  request from requester 2
- req1  input  1  request from requester 1
- req0  input  1  request from requester 0
- gnt3  output 1  grant to requester 3, registered
- gnt2  output 1  grant to requester 2, registered
- gnt1  output 1  grant to requester 1, registered
- gnt0  output 1  grant to requester 0, registered

Behaviour:
- Port order in instantiation is exactly: clk, rst, req3, req2, req1, req0, gnt3, gnt2, gnt1, gnt0.
- State:
  - grant register g[3:0], one-hot or all-zero;
  - last-owner pointer p[1:0].
- Reset (rst=0, asynchronous, immediate, including mid-operation): g=0000 (all gnt low); p=3, so requester 0 has highest priority after reset.
- Reset release: first evaluation happens at the first rising clk edge with rst=1.
- Each rising edge with rst=1, computed from sampled req[3:0] and current g:
  - Hold: if the current owner k (g[k]=1) still has req[k]=1, g is unchanged and p is unchanged.
  - Arbitrate: otherwise (no owner, or owner's req=0), scan requesters in order p+1, p+2, p+3, p+4 (mod 4). Grant the first with req=1: g = one-hot(that index), p = that index.
  - Idle: if no req is high, g=0000 and p is unchanged.
- Latency: a req sampled high at edge N with no competing owner gives gnt high immediately after edge N (one-cycle registered latency). The gnt is low during the cycle req is first presented.
- Release: owner drops req before edge N, so its gnt falls after edge N. In the same edge the next requester (round-robin) is granted. No dead cycle is inserted.
- Outputs:
  - never more than one gnt high;
  - no gnt high unless its req was high at the granting edge;
  - grants are driven directly from flops (glitch-free).
- A non-owner's req toggling while another requester holds the grant has no effect on g.
- Simultaneous new requests are resolved purely by the rotating pointer. There is no fixed priority except immediately after reset (0>1>2>3).
- Reset asserted while a grant is held: gnt drops immediately and the pointer returns to 3. The next grant after release follows 0>1>2>3 order.

Test Plan:
- Reset: rst=0 with all req=1 -> all gnt=0 throughout. Release rst, next edge -> gnt0=1 only.
- Single request: req0=1 at edge N -> gnt0=1 after N. req0=0 at edge N+1 -> gnt0=0 after N+1, all gnt=0.
- Rotation with lock (after gnt0 served, p=0): req0=req1=1 -> gnt1=1 and held while req1=1.
  - Then req1=0, req2=1 (req0 still 1) -> gnt2.
  - Then req2=0, req3=1 -> gnt3.
  - Then req3=0 -> gnt0.
  - Then req0=0 -> all gnt=0.
- Fairness: all four req held continuously, owner drops and re-raises req one cycle after each grant -> grants cycle 0,1,2,3,0. No requester is granted twice before every other active requester.
- Async reset mid-grant: gnt2=1, assert rst=0 between edges -> gnt2 falls before the next clk edge. After release with req1=req3=1 -> gnt1.
- Invariant check every cycle: popcount(gnt)<=1, and gnt[k] implies req[k] was sampled high at the previous edge.

Source files
------------

// File: rtl/arbiter_if.sv
// Request/grant bundle for the four-requester arbiter.
//   req[3:0] : request lines, driven by the requesters (master side)
//   gnt[3:0] : one-hot grant lines, driven by the arbiter (slave side)
// The arbiter itself exposes the individual req3..req0 / gnt3..gnt0 pins,
// so this bundle is wired to it bit by bit at the point of instantiation.
interface arbiter_if;
  logic [3:0] req;
  wire  [3:0] gnt;

  modport master (output req, input  gnt);
  modport slave  (input  req, output gnt);
endinterface

// File: rtl/arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grants.
// A requester keeps the grant for as long as it holds its request. When the
// owner releases, the next requester after the last owner, in rotating order,
// is granted on the same edge, so no idle cycle is inserted between owners.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   req3..req0  request inputs
//   gnt3..gnt0  grant outputs, driven directly from flops
module arbiter (
  input  logic clk,
  input  logic rst,
  input  logic req3,
  input  logic req2,
  input  logic req1,
  input  logic req0,
  output logic gnt3,
  output logic gnt2,
  output logic gnt1,
  output logic gnt0
);

  logic [3:0] req;
  logic [3:0] g;
  logic [3:0] g_nxt;
  logic [1:0] p;
  logic [1:0] p_nxt;
  logic [1:0] idx;
  logic       found;
  logic       hold;

  assign req = {req3, req2, req1, req0};

  // The owner keeps the grant while its own request stays high.
  assign hold = |(g & req);

  always_comb begin
    g_nxt = g;
    p_nxt = p;
    idx   = '0;
    found = 1'b0;
    if (!hold) begin
      g_nxt = '0;
      // Scan p+1 .. p+4; the 2-bit sum wraps, so p itself is visited last.
      for (int i = 1; i <= 4; i++) begin
        idx = p + 2'(i);
        if (!found && req[idx]) begin
          g_nxt      = '0;
          g_nxt[idx] = 1'b1;
          p_nxt      = idx;
          found      = 1'b1;
        end
      end
    end
  end

  // Pointer resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g <= '0;
      p <= 2'd3;
    end else begin
      g <= g_nxt;
      p <= p_nxt;
    end
  end

  assign {gnt3, gnt2, gnt1, gnt0} = g;

endmodule

// File: tb/tb_arbiter.sv
module tb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req_s = '0;
  logic chk_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  arbiter_if bus();

  arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .req3 (bus.req[3]),
    .req2 (bus.req[2]),
    .req1 (bus.req[1]),
    .req0 (bus.req[0]),
    .gnt3 (bus.gnt[3]),
    .gnt2 (bus.gnt[2]),
    .gnt1 (bus.gnt[1]),
    .gnt0 (bus.gnt[0])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply a request pattern, take one edge, compare grants.
  task automatic vec(input string tag, input logic [3:0] r, input logic [3:0] exp);
    bus.req = r;
    step();
    chk(tag, bus.gnt, exp);
  endtask

  always @(posedge clk) req_s <= bus.req;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("onehot", 4'($countones(bus.gnt) <= 1), 4'd1);
      chk("gnt_without_req", bus.gnt & ~req_s, 4'b0000);
    end
  end

  initial begin
    bus.req = 4'b1111;
    rst = 1'b0;
    #2;
    chk_en = 1'b1;
    chk("reset_gnt0", bus.gnt, 4'b0000);
    step();
    chk("reset_gnt1", bus.gnt, 4'b0000);
    step();
    chk("reset_gnt2", bus.gnt, 4'b0000);
    rst = 1'b1;
    chk("release_before_edge", bus.gnt, 4'b0000);
    vec("release_first", 4'b1111, 4'b0001);
    vec("drop_all", 4'b0000, 4'b0000);          // p=0

    // Single request: latency and release
    bus.req = 4'b0001;
    #2;
    chk("single_same_cycle", bus.gnt, 4'b0000);
    step();
    chk("single_grant", bus.gnt, 4'b0001);
    vec("single_release", 4'b0000, 4'b0000);    // p=0

    // Rotation with lock
    vec("rot_gnt1", 4'b0011, 4'b0010);
    vec("rot_hold1", 4'b0011, 4'b0010);
    vec("rot_nonowner_drop", 4'b0010, 4'b0010);
    vec("rot_nonowner_raise", 4'b0011, 4'b0010);
    vec("rot_gnt2", 4'b0101, 4'b0100);
    vec("rot_gnt3", 4'b1001, 4'b1000);
    vec("rot_gnt0", 4'b0001, 4'b0001);
    vec("rot_idle", 4'b0000, 4'b0000);          // p=0

    // Fairness: all requesting, owner drops for one cycle each time
    vec("fair_1", 4'b1111, 4'b0010);
    vec("fair_2", 4'b1101, 4'b0100);
    vec("fair_3", 4'b1011, 4'b1000);
    vec("fair_0", 4'b0111, 4'b0001);
    vec("fair_1b", 4'b1110, 4'b0010);           // p=1

    // Async reset while requester 2 owns the resource
    vec("pre_rst_gnt2", 4'b0100, 4'b0100);
    rst = 1'b0;
    #2;
    chk("async_drop", bus.gnt, 4'b0000);
    bus.req = 4'b1010;
    step();
    chk("in_reset", bus.gnt, 4'b0000);
    rst = 1'b1;
    vec("post_rst_gnt1", 4'b1010, 4'b0010);
    vec("post_rst_gnt3", 4'b1000, 4'b1000);
    vec("final_idle", 4'b0000, 4'b0000);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
